// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle control unit.
// Holds opcode values, ALU operation codes, PC source codes and the FSM state encoding.
package ctrl_pkg;

  // Opcode values; anything above OP_J is illegal.
  localparam int unsigned OP_R    = 0;
  localparam int unsigned OP_LW   = 1;
  localparam int unsigned OP_SW   = 2;
  localparam int unsigned OP_BEQ  = 3;
  localparam int unsigned OP_ADDI = 4;
  localparam int unsigned OP_J    = 5;

  // ALU operation codes.
  localparam logic [2:0] ALU_RTYPE = 3'b100;
  localparam logic [2:0] ALU_ADD   = 3'b001;
  localparam logic [2:0] ALU_SUB   = 3'b010;

  // PC source select codes.
  localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    StRst,
    StFetch,
    StDecode,
    StExecR,
    StAddr,
    StMemRd,
    StMemWr,
    StWbMem,
    StWbAlu,
    StBranch,
    StJump,
    StTrap
  } state_e;

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait timer: counts consecutive stalled cycles of a memory access.
// Ports:
//   clk     - clock
//   rst     - synchronous active-high reset
//   clear   - restart the count (memory answered or the FSM changed state)
//   wait_en - a memory access is in progress and memory is not ready this cycle
//   expired - TIMEOUT stalled cycles already elapsed and memory is still not ready
module mem_wait_timer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic wait_en,
  output logic expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (wait_en && (count_q != CntW'(TIMEOUT))) begin
      count_d = count_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // A ready in the cycle the count sits at TIMEOUT still wins: wait_en is low then.
  assign expired = wait_en && (count_q == CntW'(TIMEOUT));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle datapath control FSM.
// Sequences each instruction through fetch/decode/execute/memory/write-back, drives the
// datapath enables and mux selects, and handshakes with a shared memory that may stall.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   opcode                   - opcode field from the instruction register
//   mem_ready                - memory finished the current access this cycle
//   pc_write, pc_write_cond  - PC load enables (unconditional / on ALU zero)
//   pc_src                   - PC source select
//   iord                     - memory address source (0 = PC, 1 = ALU result)
//   ir_write                 - instruction register load
//   mem_read, mem_write      - memory strobes, held until mem_ready
//   reg_write, reg_dst, alu_src, mem_to_reg, ext_op, alu_op - datapath controls
//   illegal, bus_err         - sticky trap flags
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned OP_W    = 4,
  parameter int unsigned ALUOP_W = 3,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OP_W-1:0]    opcode,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic [1:0]         pc_src,
  output logic               iord,
  output logic               ir_write,
  output logic               mem_read,
  output logic               mem_write,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               alu_src,
  output logic               mem_to_reg,
  output logic               ext_op,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               illegal,
  output logic               bus_err
);

  state_e            state_q, state_d;
  logic [OP_W-1:0]   op_q;
  logic              illegal_q, bus_err_q;
  logic              set_illegal;
  logic              wait_en, expired, timer_clear;

  assign wait_en     = (state_q inside {StFetch, StMemRd, StMemWr}) && !mem_ready;
  assign timer_clear = mem_ready || (state_d != state_q);

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_mem_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .wait_en (wait_en),
    .expired (expired)
  );

  always_comb begin
    state_d     = state_q;
    set_illegal = 1'b0;
    case (state_q)
      StRst:    state_d = StFetch;
      StFetch: begin
        if (mem_ready)    state_d = StDecode;
        else if (expired) state_d = StTrap;
      end
      StDecode: begin
        case (opcode)
          OP_W'(OP_R):                              state_d = StExecR;
          OP_W'(OP_LW), OP_W'(OP_SW), OP_W'(OP_ADDI): state_d = StAddr;
          OP_W'(OP_BEQ):                            state_d = StBranch;
          OP_W'(OP_J):                              state_d = StJump;
          default: begin
            state_d     = StTrap;
            set_illegal = 1'b1;
          end
        endcase
      end
      StExecR:  state_d = StWbAlu;
      StAddr: begin
        // Only LW, SW and ADDI reach here, so anything else is ADDI.
        if (op_q == OP_W'(OP_LW))      state_d = StMemRd;
        else if (op_q == OP_W'(OP_SW)) state_d = StMemWr;
        else                           state_d = StWbAlu;
      end
      StMemRd: begin
        if (mem_ready)    state_d = StWbMem;
        else if (expired) state_d = StTrap;
      end
      StMemWr: begin
        if (mem_ready)    state_d = StFetch;
        else if (expired) state_d = StTrap;
      end
      StWbMem, StWbAlu, StBranch, StJump: state_d = StFetch;
      StTrap:   state_d = StTrap;
      default:  state_d = StRst;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StRst;
      op_q      <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StDecode) op_q <= opcode;
      if (set_illegal)         illegal_q <= 1'b1;
      if (expired)             bus_err_q <= 1'b1;
    end
  end

  // Outputs decode the state register; forced low while rst is held so an
  // aborted write never strobes during reset.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = PC_SRC_SEQ;
    iord          = 1'b0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    alu_src       = 1'b0;
    mem_to_reg    = 1'b0;
    ext_op        = 1'b0;
    alu_op        = '0;
    illegal       = 1'b0;
    bus_err       = 1'b0;
    if (!rst) begin
      illegal = illegal_q;
      bus_err = bus_err_q;
      case (state_q)
        StFetch: begin
          mem_read = 1'b1;
          ir_write = mem_ready;
          pc_write = mem_ready;
        end
        StDecode, StAddr: begin
          alu_src = 1'b1;
          ext_op  = 1'b1;
          alu_op  = ALUOP_W'(ALU_ADD);
        end
        StExecR: alu_op = ALUOP_W'(ALU_RTYPE);
        StMemRd: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        StMemWr: begin
          mem_write = 1'b1;
          iord      = 1'b1;
        end
        StWbMem: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        StWbAlu: begin
          reg_write = 1'b1;
          reg_dst   = (op_q == OP_W'(OP_R));
        end
        StBranch: begin
          alu_op        = ALUOP_W'(ALU_SUB);
          pc_write_cond = 1'b1;
          pc_src        = PC_SRC_BRANCH;
        end
        StJump: begin
          pc_write = 1'b1;
          pc_src   = PC_SRC_JUMP;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed corner cases plus a random
// instruction stream checked cycle by cycle against per-instruction phase tables.
module tb_multicycle_ctrl;

  localparam int Tmo = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] opcode = '0;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, iord, ir_write, mem_read, mem_write;
  logic       reg_write, reg_dst, alu_src, mem_to_reg, ext_op, illegal, bus_err;
  logic [1:0] pc_src;
  logic [2:0] alu_op;

  multicycle_ctrl #(
    .OP_W    (4),
    .ALUOP_W (3),
    .TIMEOUT (Tmo)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .pc_src        (pc_src),
    .iord          (iord),
    .ir_write      (ir_write),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .reg_write     (reg_write),
    .reg_dst       (reg_dst),
    .alu_src       (alu_src),
    .mem_to_reg    (mem_to_reg),
    .ext_op        (ext_op),
    .alu_op        (alu_op),
    .illegal       (illegal),
    .bus_err       (bus_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       iord;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       ext_op;
    logic [2:0] alu_op;
    logic       illegal;
    logic       bus_err;
  } outs_t;

  int n_checks = 0;
  int n_err    = 0;

  function automatic outs_t observed();
    outs_t o;
    o.pc_write      = pc_write;
    o.pc_write_cond = pc_write_cond;
    o.pc_src        = pc_src;
    o.iord          = iord;
    o.ir_write      = ir_write;
    o.mem_read      = mem_read;
    o.mem_write     = mem_write;
    o.reg_write     = reg_write;
    o.reg_dst       = reg_dst;
    o.alu_src       = alu_src;
    o.mem_to_reg    = mem_to_reg;
    o.ext_op        = ext_op;
    o.alu_op        = alu_op;
    o.illegal       = illegal;
    o.bus_err       = bus_err;
    return o;
  endfunction

  task automatic check(input string tag, input outs_t e);
    outs_t o;
    o = observed();
    n_checks++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, o, e);
    end
  endtask

  // One clock cycle: inputs applied just after the edge, outputs sampled mid-cycle.
  task automatic cyc(input logic rdy, input string tag, input outs_t e);
    mem_ready = rdy;
    #2;
    check(tag, e);
    @(posedge clk);
    #1;
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic do_reset();
    outs_t z;
    z   = '0;
    rst = 1'b1;
    cyc(rnd_bit(), "in_reset", z);
    cyc(rnd_bit(), "in_reset2", z);
    rst = 1'b0;
    cyc(rnd_bit(), "after_release", z);
  endtask

  task automatic fetch_decode(input logic [3:0] op, input int fstall);
    outs_t e;
    opcode = op;
    for (int i = 0; i < fstall; i++) begin
      e = '0; e.mem_read = 1'b1;
      cyc(1'b0, "fetch_wait", e);
    end
    e = '0; e.mem_read = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
    cyc(1'b1, "fetch_done", e);
    e = '0; e.alu_src = 1'b1; e.ext_op = 1'b1; e.alu_op = 3'b001;
    cyc(rnd_bit(), "decode", e);
    // Opcode is held only through decode; later phases must not depend on it.
    opcode = 4'($urandom);
  endtask

  task automatic run_instr(input logic [3:0] op, input int fstall, input int mstall);
    outs_t e, addr;
    fetch_decode(op, fstall);
    addr = '0; addr.alu_src = 1'b1; addr.ext_op = 1'b1; addr.alu_op = 3'b001;
    case (op)
      4'd0: begin
        e = '0; e.alu_op = 3'b100;
        cyc(rnd_bit(), "exec_r", e);
        e = '0; e.reg_write = 1'b1; e.reg_dst = 1'b1;
        cyc(rnd_bit(), "wb_r", e);
      end
      4'd4: begin
        cyc(rnd_bit(), "addr_addi", addr);
        e = '0; e.reg_write = 1'b1;
        cyc(rnd_bit(), "wb_addi", e);
      end
      4'd1: begin
        cyc(rnd_bit(), "addr_lw", addr);
        e = '0; e.mem_read = 1'b1; e.iord = 1'b1;
        for (int i = 0; i < mstall; i++) cyc(1'b0, "lw_wait", e);
        cyc(1'b1, "lw_done", e);
        e = '0; e.reg_write = 1'b1; e.mem_to_reg = 1'b1;
        cyc(rnd_bit(), "wb_lw", e);
      end
      4'd2: begin
        cyc(rnd_bit(), "addr_sw", addr);
        e = '0; e.mem_write = 1'b1; e.iord = 1'b1;
        for (int i = 0; i < mstall; i++) cyc(1'b0, "sw_wait", e);
        cyc(1'b1, "sw_done", e);
      end
      4'd3: begin
        e = '0; e.alu_op = 3'b010; e.pc_write_cond = 1'b1; e.pc_src = 2'b01;
        cyc(rnd_bit(), "branch", e);
      end
      default: begin
        e = '0; e.pc_write = 1'b1; e.pc_src = 2'b10;
        cyc(rnd_bit(), "jump", e);
      end
    endcase
  endtask

  function automatic int pick_stall();
    return ($urandom_range(0, 7) == 0) ? Tmo : int'($urandom_range(0, 3));
  endfunction

  initial begin
    outs_t e;

    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Directed: each class once with zero wait, LW with 3 stalls, BEQ then J.
    run_instr(4'd0, 0, 0);
    run_instr(4'd4, 0, 0);
    run_instr(4'd1, 0, 3);
    run_instr(4'd2, 0, 0);
    run_instr(4'd3, 0, 0);
    run_instr(4'd5, 0, 0);

    // Ready arriving while the wait count sits at TIMEOUT is still a success.
    run_instr(4'd0, Tmo, 0);
    run_instr(4'd1, 1, Tmo);
    run_instr(4'd2, 2, Tmo);

    // Illegal opcode traps after decode and holds until reset.
    fetch_decode(4'b1010, 0);
    e = '0; e.illegal = 1'b1;
    for (int i = 0; i < 20; i++) cyc(rnd_bit(), "trap_illegal", e);
    do_reset();
    run_instr(4'd0, 0, 0);

    // Fetch timeout: TIMEOUT+1 consecutive not-ready cycles raise bus_err.
    opcode = 4'd0;
    e = '0; e.mem_read = 1'b1;
    for (int i = 0; i <= Tmo; i++) cyc(1'b0, "fetch_timeout_wait", e);
    e = '0; e.bus_err = 1'b1;
    for (int i = 0; i < 5; i++) cyc(rnd_bit(), "trap_bus_err", e);
    do_reset();

    // Read timeout in the memory phase.
    fetch_decode(4'd1, 0);
    e = '0; e.alu_src = 1'b1; e.ext_op = 1'b1; e.alu_op = 3'b001;
    cyc(rnd_bit(), "addr_lw_to", e);
    e = '0; e.mem_read = 1'b1; e.iord = 1'b1;
    for (int i = 0; i <= Tmo; i++) cyc(1'b0, "lw_timeout_wait", e);
    e = '0; e.bus_err = 1'b1;
    cyc(rnd_bit(), "trap_bus_err_rd", e);
    do_reset();

    // Reset during a stalled write aborts without a further write strobe.
    fetch_decode(4'd2, 0);
    e = '0; e.alu_src = 1'b1; e.ext_op = 1'b1; e.alu_op = 3'b001;
    cyc(rnd_bit(), "addr_sw_abort", e);
    e = '0; e.mem_write = 1'b1; e.iord = 1'b1;
    cyc(1'b0, "sw_wait_abort", e);
    cyc(1'b0, "sw_wait_abort2", e);
    rst = 1'b1;
    e = '0;
    cyc(1'b0, "rst_during_sw", e);
    rst = 1'b0;
    cyc(1'b1, "rst_state_after_sw", e);
    run_instr(4'd2, 0, 1);

    // Random instruction stream with random stalls.
    for (int n = 0; n < 60; n++) begin
      run_instr(4'($urandom_range(0, 5)), pick_stall(), pick_stall());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
